pending_interest_table: RTL and testbench

PENDING_INTEREST_TABLE -- requirements
Module: pending_interest_table

---
 rtl/pit_pkg.sv | 17 +
 rtl/pending_interest_table.sv | 127 ++++++++++++
 tb/tb_pending_interest_table.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pit_pkg.sv
// Shared types and constants for the pending interest table.
package pit_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_DECIDE = 2'd2,
    S_DONE   = 2'd3
  } pit_state_t;

  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 8;
  localparam int ENTRY_W_DEF = 12;

  localparam logic [7:0] EMPTY_SLOT = 8'hFF;

endpackage

// File: rtl/pending_interest_table.sv
// Pending interest table controller: one read-decide-write pass over a
// synchronous memory slot per interest or data request.
module pending_interest_table
  import pit_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ENTRY_W = ENTRY_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ENTRY_W-1:0] table_entry,
  input  logic               in_bit,
  input  logic               out_bit,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [DATA_W-1:0]  read_data,
  output logic [ADDR_W-1:0]  address,
  output logic [DATA_W-1:0]  out_data,
  output logic               write_enable,
  output logic               fib_out,
  output logic               start_bit
);

  localparam logic [DATA_W-1:0] EMPTY = DATA_W'(EMPTY_SLOT);

  pit_state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_slot,    w_slot_nxt;
  logic [DATA_W-1:0] r_face,    w_face_nxt;
  logic              r_is_data, w_is_data_nxt;
  logic              r_clear,   w_clear_nxt;

  logic [ADDR_W-1:0] r_address, w_address_nxt;
  logic [DATA_W-1:0] r_out_data, w_out_data_nxt;
  logic              r_we, w_we_nxt;
  logic              r_fib, w_fib_nxt;
  logic              r_start, w_start_nxt;

  // Upper table_entry bits are reserved.
  logic w_unused_entry;
  assign w_unused_entry = ^table_entry[ENTRY_W-1:ADDR_W];

  always_comb begin
    w_state_nxt    = r_state;
    w_slot_nxt     = r_slot;
    w_face_nxt     = r_face;
    w_is_data_nxt  = r_is_data;
    w_clear_nxt    = 1'b0;
    w_address_nxt  = r_address;
    w_out_data_nxt = '0;
    w_we_nxt       = 1'b0;
    w_fib_nxt      = 1'b0;
    w_start_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (in_bit || out_bit) begin
          w_slot_nxt    = table_entry[ADDR_W-1:0];
          w_face_nxt    = in_data;
          w_is_data_nxt = out_bit;
          w_address_nxt = table_entry[ADDR_W-1:0];
          w_state_nxt   = S_READ;
        end
      end
      S_READ: begin
        w_address_nxt = r_slot;
        w_state_nxt   = S_DECIDE;
      end
      S_DECIDE: begin
        w_state_nxt = S_DONE;
        if (!r_is_data) begin
          if (read_data == EMPTY) begin
            w_out_data_nxt = r_face;
            w_we_nxt       = 1'b1;
            w_fib_nxt      = 1'b1;
          end
        end else if (read_data != EMPTY) begin
          // Face goes out now; the slot clear follows one cycle later.
          w_out_data_nxt = read_data;
          w_start_nxt    = 1'b1;
          w_clear_nxt    = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (r_clear) begin
          w_out_data_nxt = EMPTY;
          w_we_nxt       = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_slot     <= '0;
      r_face     <= '0;
      r_is_data  <= 1'b0;
      r_clear    <= 1'b0;
      r_address  <= '0;
      r_out_data <= '0;
      r_we       <= 1'b0;
      r_fib      <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_face     <= w_face_nxt;
      r_is_data  <= w_is_data_nxt;
      r_clear    <= w_clear_nxt;
      r_address  <= w_address_nxt;
      r_out_data <= w_out_data_nxt;
      r_we       <= w_we_nxt;
      r_fib      <= w_fib_nxt;
      r_start    <= w_start_nxt;
    end
  end

  assign address      = r_address;
  assign out_data     = r_out_data;
  assign write_enable = r_we;
  assign fib_out      = r_fib;
  assign start_bit    = r_start;

endmodule

// File: tb/tb_pending_interest_table.sv
// Self-checking bench: table of requests with a per-cycle expected-output
// scoreboard, plus reset and held-strobe sequences.
module tb_pending_interest_table;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] table_entry = '0;
  logic        in_bit = 1'b0;
  logic        out_bit = 1'b0;
  logic [7:0]  in_data = '0;
  logic [7:0]  read_data = 8'hFF;
  logic [9:0]  address;
  logic [7:0]  out_data;
  logic        write_enable;
  logic        fib_out;
  logic        start_bit;

  pending_interest_table dut (
    .clk          (clk),
    .reset        (reset),
    .table_entry  (table_entry),
    .in_bit       (in_bit),
    .out_bit      (out_bit),
    .in_data      (in_data),
    .read_data    (read_data),
    .address      (address),
    .out_data     (out_data),
    .write_enable (write_enable),
    .fib_out      (fib_out),
    .start_bit    (start_bit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ib;
    logic        ob;
    logic [11:0] te;
    logic [7:0]  ind;
    logic [7:0]  rd;
  } vec_t;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
    logic       we;
    logic       fib;
    logic       st;
  } obs_t;

  obs_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic obs_t sample();
    return '{a: address, d: out_data, we: write_enable, fib: fib_out, st: start_bit};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got addr=%h data=%h we=%b fib=%b start=%b, want addr=%h data=%h we=%b fib=%b start=%b",
               name, got.a, got.d, got.we, got.fib, got.st, exp.a, exp.d, exp.we, exp.fib, exp.st);
    end
  endtask

  // Reference behaviour: four observed cycles after the accepting edge.
  function automatic void push_expect(input vec_t v);
    logic [9:0] slot;
    obs_t       idle_o;
    slot   = v.te[9:0];
    idle_o = '{a: slot, d: 8'h00, we: 1'b0, fib: 1'b0, st: 1'b0};
    q.push_back(idle_o);
    q.push_back(idle_o);
    if (v.ob) begin
      if (v.rd != 8'hFF) begin
        q.push_back('{a: slot, d: v.rd, we: 1'b0, fib: 1'b0, st: 1'b1});
        q.push_back('{a: slot, d: 8'hFF, we: 1'b1, fib: 1'b0, st: 1'b0});
      end else begin
        q.push_back(idle_o);
        q.push_back(idle_o);
      end
    end else begin
      if (v.rd == 8'hFF) q.push_back('{a: slot, d: v.ind, we: 1'b1, fib: 1'b1, st: 1'b0});
      else               q.push_back(idle_o);
      q.push_back(idle_o);
    end
  endfunction

  task automatic apply(input vec_t v, input int hold, input string name);
    @(negedge clk);
    in_bit      = v.ib;
    out_bit     = v.ob;
    table_entry = v.te;
    in_data     = v.ind;
    read_data   = v.rd;
    push_expect(v);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k + 1 >= hold) begin
        in_bit  = 1'b0;
        out_bit = 1'b0;
      end
      @(negedge clk);
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: scoreboard empty at cycle %0d, want 1 entry", name, k);
      end else begin
        check($sformatf("%s_c%0d", name, k), sample(), q.pop_front());
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, want completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ib: 1, ob: 0, te: 12'h111, ind: 8'h05, rd: 8'hFF}; // new interest
    vecs[1] = '{ib: 1, ob: 0, te: 12'h111, ind: 8'h07, rd: 8'h05}; // aggregate
    vecs[2] = '{ib: 0, ob: 1, te: 12'h111, ind: 8'h00, rd: 8'h05}; // data hit
    vecs[3] = '{ib: 0, ob: 1, te: 12'h111, ind: 8'h00, rd: 8'hFF}; // data miss
    vecs[4] = '{ib: 1, ob: 1, te: 12'h2A3, ind: 8'h09, rd: 8'h33}; // both -> data
    vecs[5] = '{ib: 1, ob: 0, te: 12'hFFF, ind: 8'h00, rd: 8'hFF}; // top slot, face 0
    vecs[6] = '{ib: 1, ob: 0, te: 12'hC00, ind: 8'hFE, rd: 8'hFF}; // slot 0, reserved bits set
    vecs[7] = '{ib: 1, ob: 1, te: 12'h055, ind: 8'h11, rd: 8'hFF}; // both, empty slot

    #12;
    check("reset_state", sample(), '0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) apply(vecs[i], 1, $sformatf("vec%0d", i));

    // Strobe held through the busy cycles must yield a single transaction.
    apply('{ib: 1, ob: 0, te: 12'h0AA, ind: 8'h21, rd: 8'hFF}, 3, "held_strobe");
    @(negedge clk);
    check("held_idle", sample(), '{a: 10'h0AA, d: 8'h00, we: 1'b0, fib: 1'b0, st: 1'b0});

    // Reset asserted while in DECIDE.
    @(negedge clk);
    in_bit = 1'b1; table_entry = 12'h111; in_data = 8'h05; read_data = 8'hFF;
    @(posedge clk); #1; in_bit = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("reset_mid_op", sample(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_quiet_c%0d", k), sample(), '0);
    end
    apply(vecs[0], 1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
